// File: rtl/vip_matrix_generate_kxk.sv
// ---------------------------------------------------------------------------
// vip_matrix_generate_kxk
//
// Builds a KSIZE x KSIZE pixel window from a raster video stream. KSIZE-1
// on-chip line buffers are chained so that buffer k returns the pixel in the
// same column k+1 lines earlier. Each accepted pixel shifts one new column
// into the window. The window appears two cycles after the pixel was
// accepted, aligned with the delayed frame strobes.
//
// Parameters
//   DATA_W     pixel width in bits
//   KSIZE      window size, 3 or 5
//   MAX_WIDTH  maximum pixels per line held in the line buffers
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   per_frame_vsync/href/clken, per_img_data   input video stream
//   matrix_frame_vsync/href/clken              input strobes delayed 2 cycles
//   matrix_data            window; tap (r,c) at bits (r*KSIZE+c)*DATA_W,
//                          r=0 oldest row, c=0 oldest column
//   matrix_valid           window lies fully inside the image
//   line_overflow          sticky per frame: a line exceeded MAX_WIDTH
//
// Build option
//   VIP_MATRIX_EDGE_ZERO_EN  when defined, taps whose source pixel lies above
//                            or left of the image are forced to zero.
// ---------------------------------------------------------------------------
module vip_matrix_generate_kxk #(
    parameter int DATA_W    = 8,
    parameter int KSIZE     = 3,
    parameter int MAX_WIDTH = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            per_frame_vsync,
    input  logic                            per_frame_href,
    input  logic                            per_frame_clken,
    input  logic [DATA_W-1:0]               per_img_data,
    output logic                            matrix_frame_vsync,
    output logic                            matrix_frame_href,
    output logic                            matrix_frame_clken,
    output logic [KSIZE*KSIZE*DATA_W-1:0]   matrix_data,
    output logic                            matrix_valid,
    output logic                            line_overflow
);

    localparam int COL_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int ROW_W = $clog2(KSIZE) + 1;
    localparam int WIN_W = KSIZE * KSIZE * DATA_W;
    localparam int VEC_W = KSIZE * DATA_W;

    logic [DATA_W-1:0] line_buf [0:KSIZE-2][0:MAX_WIDTH-1];

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             line_full;
    logic             href_prev;
    logic             vsync_prev;

    logic             d1_vsync;
    logic             d1_href;
    logic             d1_clken;
    logic [VEC_W-1:0] d1_col_vec;
    logic [ROW_W-1:0] d1_row;
    logic [COL_W-1:0] d1_col;

    logic [VEC_W-1:0] col_vec;
    logic [WIN_W-1:0] window;
    logic [WIN_W-1:0] window_next;

    logic accept;
    logic href_fall;
    logic vsync_rise;
    logic wr_en;

    assign accept     = per_frame_href & per_frame_clken;
    assign href_fall  = href_prev & ~per_frame_href;
    assign vsync_rise = per_frame_vsync & ~vsync_prev;
    assign wr_en      = accept & ~line_full;

    // New window column for the pixel at the current column: the live pixel
    // sits in the bottom row, line buffer k supplies the row k+1 lines above.
    // The read sees the contents before this cycle's write.
    always_comb begin
        col_vec = '0;
        col_vec[(KSIZE-1)*DATA_W +: DATA_W] = per_img_data;
        for (int k = 0; k < KSIZE-1; k++) begin
            col_vec[(KSIZE-2-k)*DATA_W +: DATA_W] = line_buf[k][col];
        end
    end

    // Line buffer chain: each buffer passes its old pixel down to the next
    // one and buffer 0 takes the live pixel. Contents are deliberately not
    // reset; writes stop once the line has filled the buffers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_buf[0][col] <= per_img_data;
            for (int k = 1; k < KSIZE-1; k++) begin
                line_buf[k][col] <= line_buf[k-1][col];
            end
        end
    end

    // Column/row position tracking and the per-frame overflow flag. The row
    // counter stops at KSIZE-1 because nothing downstream distinguishes rows
    // beyond that. An overflowing pixel arriving together with a vsync rise
    // leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col           <= '0;
            row           <= '0;
            line_full     <= 1'b0;
            href_prev     <= 1'b0;
            vsync_prev    <= 1'b0;
            line_overflow <= 1'b0;
        end else begin
            href_prev  <= per_frame_href;
            vsync_prev <= per_frame_vsync;
            if (href_fall) begin
                col       <= '0;
                line_full <= 1'b0;
            end else if (accept) begin
                if (col == COL_W'(MAX_WIDTH-1)) begin
                    line_full <= 1'b1;
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (vsync_rise) begin
                row <= '0;
            end else if (href_fall && (row != ROW_W'(KSIZE-1))) begin
                row <= row + ROW_W'(1);
            end
            if (accept && line_full) begin
                line_overflow <= 1'b1;
            end else if (vsync_rise) begin
                line_overflow <= 1'b0;
            end
        end
    end

    // First pipeline stage: capture the strobes, the assembled column and
    // the source coordinates of the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_vsync   <= 1'b0;
            d1_href    <= 1'b0;
            d1_clken   <= 1'b0;
            d1_col_vec <= '0;
            d1_row     <= '0;
            d1_col     <= '0;
        end else begin
            d1_vsync   <= per_frame_vsync;
            d1_href    <= per_frame_href;
            d1_clken   <= per_frame_clken;
            d1_col_vec <= col_vec;
            d1_row     <= row;
            d1_col     <= col;
        end
    end

    // Shift the window left by one column and append the new column on the
    // right (newest column is c = KSIZE-1).
    always_comb begin
        window_next = window;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if (c < KSIZE-1) begin
                    window_next[(r*KSIZE+c)*DATA_W +: DATA_W] =
                        window[(r*KSIZE+c+1)*DATA_W +: DATA_W];
                end else begin
                    window_next[(r*KSIZE+c)*DATA_W +: DATA_W] =
                        d1_col_vec[r*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Second pipeline stage: the window clears outside a line, shifts on an
    // accepted pixel and holds across strobe gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_frame_vsync <= 1'b0;
            matrix_frame_href  <= 1'b0;
            matrix_frame_clken <= 1'b0;
            matrix_valid       <= 1'b0;
            window             <= '0;
        end else begin
            matrix_frame_vsync <= d1_vsync;
            matrix_frame_href  <= d1_href;
            matrix_frame_clken <= d1_clken;
            matrix_valid       <= d1_href && d1_clken &&
                                  (d1_row >= ROW_W'(KSIZE-1)) &&
                                  (d1_col >= COL_W'(KSIZE-1));
            if (!d1_href) begin
                window <= '0;
            end else if (d1_clken) begin
                window <= window_next;
            end
        end
    end

`ifdef VIP_MATRIX_EDGE_ZERO_EN
    logic [ROW_W-1:0] d2_row;
    logic [COL_W-1:0] d2_col;

    // Coordinates of the pixel currently at the window's bottom-right tap,
    // held across strobe gaps so the edge mask stays with the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d2_row <= '0;
            d2_col <= '0;
        end else if (d1_href && d1_clken) begin
            d2_row <= d1_row;
            d2_col <= d1_col;
        end
    end

    // Zero any tap whose source row or column falls before the image start.
    always_comb begin
        matrix_data = window;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                if ((int'(d2_row) < KSIZE-1-r) || (int'(d2_col) < KSIZE-1-c)) begin
                    matrix_data[(r*KSIZE+c)*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end
`else
    assign matrix_data = window;
`endif

endmodule
